// File: rtl/image_pingpong_buffer.sv
// Ping-pong frame store: a loader fills one bank while the other bank is read, and a counter-driven sweep zeroes the write bank.
// Optional macro IMAGE_BUF_ADDR_CHECK_EN enables a sticky out-of-range address flag on o_addr_err.
module image_pingpong_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 784,
   parameter int ADDR_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_clear_start,
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic signed [DATA_W-1:0] i_wr_data,
   input  logic                     i_frame_done,
   input  logic                     i_rd_en,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   output logic signed [DATA_W-1:0] o_rd_data,
   output logic                     o_rd_valid,
   output logic                     o_busy,
   output logic                     o_wr_bank,
   output logic                     o_frame_ready,
   output logic                     o_addr_err
);

   // state    | meaning
   // ST_IDLE  | accepting writes, swaps and clear requests
   // ST_CLEAR | zeroing write bank word r_cnt; other write-side requests ignored

   localparam int                IDX_W   = $clog2(2 * DEPTH);
   localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ADDR_W-1:0]          r_cnt;
   logic                       r_wr_bank;
   logic                       r_frame_ready;
   logic signed [DATA_W-1:0]   r_rd_data;
   logic                       r_rd_valid;

   logic                       w_idle;
   logic                       w_clearing;
   logic                       w_last;
   logic                       w_wr_in_range;
   logic                       w_rd_in_range;
   logic                       w_mem_we;
   logic [ADDR_W-1:0]          w_mem_addr;
   logic signed [DATA_W-1:0]   w_mem_wdata;
   logic [IDX_W-1:0]           w_wbase;
   logic [IDX_W-1:0]           w_rbase;
   logic [IDX_W-1:0]           w_widx;
   logic [IDX_W-1:0]           w_ridx;

   // Both banks live in one array: bank b occupies [b*DEPTH, b*DEPTH+DEPTH-1].
   logic signed [DATA_W-1:0]   r_mem [0:2*DEPTH-1];

   assign w_idle        = (r_state == ST_IDLE);
   assign w_clearing    = (r_state == ST_CLEAR);
   assign w_last        = (r_cnt == LP_LAST);
   assign w_wr_in_range = (i_wr_addr < LP_DEPTH);
   assign w_rd_in_range = (i_rd_addr < LP_DEPTH);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_clear_start) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (w_last)        w_state_nxt = ST_IDLE;
         default:                     w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (w_clearing && !w_last) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_bank     <= 1'b0;
         r_frame_ready <= 1'b0;
      end else if (w_idle && i_frame_done) begin
         r_wr_bank     <= ~r_wr_bank;
         r_frame_ready <= 1'b1;
      end
   end

   // Single write port shared by the sweep and the loader; the sweep owns it while clearing.
   // Writes are suppressed on a reset edge so an aborted sweep leaves untouched words intact.
   assign w_mem_we    = !i_reset && (w_clearing || (w_idle && i_wr_en && w_wr_in_range));
   assign w_mem_addr  = w_clearing ? r_cnt : i_wr_addr;
   assign w_mem_wdata = w_clearing ? '0 : i_wr_data;

   assign w_wbase = r_wr_bank ? IDX_W'(DEPTH) : IDX_W'(0);
   assign w_rbase = r_wr_bank ? IDX_W'(0)     : IDX_W'(DEPTH);
   assign w_widx  = w_wbase + IDX_W'(w_mem_addr);
   assign w_ridx  = w_rbase + IDX_W'(i_rd_addr);

   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_widx] <= w_mem_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rd_data <= w_rd_in_range ? r_mem[w_ridx] : '0;
         end
      end
   end

`ifdef IMAGE_BUF_ADDR_CHECK_EN
   logic r_addr_err;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_addr_err <= 1'b0;
      end else if ((w_idle && i_wr_en && !w_wr_in_range) || (i_rd_en && !w_rd_in_range)) begin
         r_addr_err <= 1'b1;
      end
   end

   assign o_addr_err = r_addr_err;
`else
   assign o_addr_err = 1'b0;
`endif

   assign o_rd_data     = r_rd_data;
   assign o_rd_valid    = r_rd_valid;
   assign o_busy        = w_clearing;
   assign o_wr_bank     = r_wr_bank;
   assign o_frame_ready = r_frame_ready;

endmodule

// File: tb/tb_image_pingpong_buffer.sv
// Directed bench for image_pingpong_buffer: writes, swaps, clear sweeps, out-of-range accesses and reset mid-sweep.
module tb_image_pingpong_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 784;
   localparam int ADDR_W = 16;

   logic                     clk;
   logic                     reset;
   logic                     clear_start;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic signed [DATA_W-1:0] wr_data;
   logic                     frame_done;
   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   logic signed [DATA_W-1:0] rd_data;
   logic                     rd_valid;
   logic                     busy;
   logic                     wr_bank;
   logic                     frame_ready;
   logic                     addr_err;

   int n_checks = 0;
   int n_errors = 0;

   image_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_clk(clk), .i_reset(reset), .i_clear_start(clear_start),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_frame_done(frame_done), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy),
      .o_wr_bank(wr_bank), .o_frame_ready(frame_ready), .o_addr_err(addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled at the falling edge, half a period from the active edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      clear_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      frame_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
   endtask

   task automatic do_write(input int addr, input int data);
      drive_idle();
      wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
      tick();
      drive_idle();
   endtask

   task automatic do_swap();
      drive_idle();
      frame_done = 1'b1;
      tick();
      drive_idle();
   endtask

   task automatic do_read(input int addr);
      drive_idle();
      rd_en = 1'b1; rd_addr = ADDR_W'(addr);
      tick();
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      tick(); tick();
      n_checks++; if (rd_data !== 32'sd0)   begin n_errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
      n_checks++; if (rd_valid !== 1'b0)    begin n_errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (wr_bank !== 1'b0)     begin n_errors++; $display("FAIL reset_wr_bank got=%b exp=0", wr_bank); end
      n_checks++; if (frame_ready !== 1'b0) begin n_errors++; $display("FAIL reset_frame_ready got=%b exp=0", frame_ready); end
      n_checks++; if (addr_err !== 1'b0)    begin n_errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_swap();
      do_write(0, -5);
      do_write(783, 1234);
      do_swap();
      n_checks++; if (wr_bank !== 1'b1)     begin n_errors++; $display("FAIL swap_wr_bank got=%b exp=1", wr_bank); end
      n_checks++; if (frame_ready !== 1'b1) begin n_errors++; $display("FAIL swap_frame_ready got=%b exp=1", frame_ready); end
      do_read(0);
      n_checks++; if (rd_valid !== 1'b1)    begin n_errors++; $display("FAIL rd0_valid got=%b exp=1", rd_valid); end
      n_checks++; if (rd_data !== -32'sd5)  begin n_errors++; $display("FAIL rd0_data got=%0d exp=-5", rd_data); end
      tick();
      n_checks++; if (rd_valid !== 1'b0)    begin n_errors++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
      n_checks++; if (rd_data !== -32'sd5)  begin n_errors++; $display("FAIL idle_rd_hold got=%0d exp=-5", rd_data); end
      do_read(783);
      n_checks++; if (rd_data !== 32'sd1234) begin n_errors++; $display("FAIL rd783_data got=%0d exp=1234", rd_data); end
   endtask

   task automatic test_clear();
      int cycles;
      int bad;
      drive_idle();
      clear_start = 1'b1;
      tick();
      drive_idle();
      cycles = 0;
      while (busy === 1'b1 && cycles < 2000) begin
         cycles++;
         drive_idle();
         if (cycles == 10) begin
            wr_en = 1'b1; wr_addr = 16'd3; wr_data = 32'sd99;
         end
         if (cycles == 20) frame_done = 1'b1;
         tick();
      end
      drive_idle();
      n_checks++; if (cycles != DEPTH) begin n_errors++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", cycles, DEPTH); end
      n_checks++; if (wr_bank !== 1'b1) begin n_errors++; $display("FAIL clear_swap_ignored got=%b exp=1", wr_bank); end
      do_swap();
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a);
         if (rd_data !== 32'sd0 || rd_valid !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_errors++; $display("FAIL clear_readback nonzero_words got=%0d exp=0", bad); end
   endtask

   task automatic test_pingpong();
      // Write bank is 0 here: put -5 at [10], then swap so bank0 becomes the read bank.
      do_write(10, -5);
      do_swap();
      do_write(10, 77);
      do_read(10);
      n_checks++; if (rd_data !== -32'sd5) begin n_errors++; $display("FAIL pp_before_swap got=%0d exp=-5", rd_data); end
      do_read(10);
      n_checks++; if (rd_data !== -32'sd5) begin n_errors++; $display("FAIL pp_before_swap2 got=%0d exp=-5", rd_data); end
      do_swap();
      do_read(10);
      n_checks++; if (rd_data !== 32'sd77) begin n_errors++; $display("FAIL pp_after_swap got=%0d exp=77", rd_data); end
   endtask

   task automatic test_write_with_swap();
      drive_idle();
      wr_en = 1'b1; wr_addr = 16'd5; wr_data = 32'sd7; frame_done = 1'b1;
      tick();
      drive_idle();
      n_checks++; if (wr_bank !== 1'b1) begin n_errors++; $display("FAIL ws_wr_bank got=%b exp=1", wr_bank); end
      do_read(5);
      n_checks++; if (rd_data !== 32'sd7) begin n_errors++; $display("FAIL ws_rd_data got=%0d exp=7", rd_data); end
   endtask

   task automatic test_out_of_range();
      do_write(784, 1);
      n_checks++; if (wr_bank !== 1'b1) begin n_errors++; $display("FAIL oor_wr_bank got=%b exp=1", wr_bank); end
`ifdef IMAGE_BUF_ADDR_CHECK_EN
      n_checks++; if (addr_err !== 1'b1) begin n_errors++; $display("FAIL oor_wr_addr_err got=%b exp=1", addr_err); end
`else
      n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL oor_wr_addr_err got=%b exp=0", addr_err); end
`endif
      // With bank0 as write bank, an unchecked address 784 would alias bank1 word 0.
      do_swap();
      do_write(784, 1);
      do_read(0);
      n_checks++; if (rd_data !== 32'sd0) begin n_errors++; $display("FAIL oor_no_wrap got=%0d exp=0", rd_data); end
      do_read(10);
      n_checks++; if (rd_data !== 32'sd77) begin n_errors++; $display("FAIL oor_pre_read got=%0d exp=77", rd_data); end
      do_read(900);
      n_checks++; if (rd_data !== 32'sd0)  begin n_errors++; $display("FAIL oor_rd_data got=%0d exp=0", rd_data); end
      n_checks++; if (rd_valid !== 1'b1)   begin n_errors++; $display("FAIL oor_rd_valid got=%b exp=1", rd_valid); end
      tick(); tick();
`ifdef IMAGE_BUF_ADDR_CHECK_EN
      n_checks++; if (addr_err !== 1'b1) begin n_errors++; $display("FAIL oor_addr_err_sticky got=%b exp=1", addr_err); end
`else
      n_checks++; if (addr_err !== 1'b0) begin n_errors++; $display("FAIL oor_addr_err_tied got=%b exp=0", addr_err); end
`endif
   endtask

   task automatic test_reset_mid_sweep();
      int cycles;
      // Write bank is 0: bank0 holds [0]=-5 and [783]=1234 before the aborted sweep.
      drive_idle();
      clear_start = 1'b1;
      tick();
      drive_idle();
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         tick();
      end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      n_checks++; if (wr_bank !== 1'b0)     begin n_errors++; $display("FAIL abort_wr_bank got=%b exp=0", wr_bank); end
      n_checks++; if (frame_ready !== 1'b0) begin n_errors++; $display("FAIL abort_frame_ready got=%b exp=0", frame_ready); end
      do_swap();
      do_read(0);
      n_checks++; if (rd_data !== 32'sd0)    begin n_errors++; $display("FAIL abort_zeroed_kept got=%0d exp=0", rd_data); end
      do_read(783);
      n_checks++; if (rd_data !== 32'sd1234) begin n_errors++; $display("FAIL abort_untouched got=%0d exp=1234", rd_data); end
      drive_idle();
      clear_start = 1'b1;
      tick();
      drive_idle();
      cycles = 0;
      while (busy === 1'b1 && cycles < 2000) begin
         cycles++;
         tick();
      end
      n_checks++; if (cycles != DEPTH) begin n_errors++; $display("FAIL resweep_cycles got=%0d exp=%0d", cycles, DEPTH); end
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_write_swap();
      test_clear();
      test_pingpong();
      test_write_with_swap();
      test_out_of_range();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
